// File: rtl/pf_fetch_if.sv
// Pre-fetch stage bus: next-PC/stall/flush controls, instruction-memory
// request/response channel, and the fetched-word handoff toward IF.
interface pf_fetch_if;
    logic [31:0] NPC;
    logic        PCWr;
    logic        PF_Flush;
    logic        IF_allowin;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic [31:0] PF_PC;
    logic        PF_valid;
    logic [31:0] PF_inst;
    logic        PF_ex;

    // Fetch-stage side.
    modport master (
        input  NPC, PCWr, PF_Flush, IF_allowin,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output inst_req, inst_addr,
        output PF_PC, PF_valid, PF_inst, PF_ex
    );

    // Environment side: next-PC logic, IF stage and instruction memory.
    modport slave (
        output NPC, PCWr, PF_Flush, IF_allowin,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  inst_req, inst_addr,
        input  PF_PC, PF_valid, PF_inst, PF_ex
    );
endinterface

// File: rtl/pf_fetch.sv
// Pre-fetch stage: issues one instruction-memory read at a time, buffers the
// returned word for IF, and discards responses that belong to fetches
// abandoned by a redirect.
module pf_fetch (
    input logic        clk,
    input logic        resetn,
    pf_fetch_if.master bus
);
    localparam logic [31:0] ResetPc = 32'hBFC0_0000;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] inst_q;
    logic [1:0]  drop_cnt_q;
    logic        redirect_pend_q;
    logic        valid_q;
    logic        ex_q;
    logic        req_q;

    logic        data_keep;
    logic        data_drop;
    logic        drop_inc;
    logic [2:0]  drop_sum;
    logic        launch;
    logic [31:0] launch_addr;

    // A response is ours only when no abandoned fetch is still in flight.
    assign data_keep = bus.inst_data_ok && (drop_cnt_q == 2'd0);
    assign data_drop = bus.inst_data_ok && (drop_cnt_q != 2'd0);

    // Decide whether this edge starts a new fetch, and from which address.
    always_comb begin
        launch      = 1'b0;
        launch_addr = bus.NPC;
        drop_inc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                launch      = 1'b1;
                launch_addr = bus.PF_Flush ? bus.NPC : pc_q;
            end
            StReq: begin
                // An accepted request that is being redirected must be drained later.
                if (bus.inst_addr_ok && (bus.PF_Flush || redirect_pend_q)) begin
                    launch      = 1'b1;
                    drop_inc    = 1'b1;
                    launch_addr = bus.PF_Flush ? bus.NPC : pc_q;
                end
            end
            StWait: begin
                if (bus.PF_Flush) begin
                    launch   = 1'b1;
                    // A same-cycle response with nothing to drop closes out the old fetch.
                    drop_inc = !data_keep;
                end
            end
            StHold: begin
                if (bus.PF_Flush || (bus.IF_allowin && bus.PCWr)) begin
                    launch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign drop_sum = {1'b0, drop_cnt_q} + {2'b00, drop_inc} - {2'b00, data_drop};

    // Fetch state machine with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            pc_q            <= ResetPc;
            req_addr_q      <= ResetPc;
            inst_q          <= 32'h0;
            drop_cnt_q      <= 2'd0;
            redirect_pend_q <= 1'b0;
            valid_q         <= 1'b0;
            ex_q            <= 1'b0;
            req_q           <= 1'b0;
        end else begin
            drop_cnt_q <= drop_sum[1:0];
            if (bus.PF_Flush) begin
                pc_q <= bus.NPC;
            end
            if (launch) begin
                pc_q            <= launch_addr;
                req_addr_q      <= launch_addr;
                redirect_pend_q <= 1'b0;
                if (launch_addr[1:0] != 2'b00) begin
                    // Misaligned target: report AdEL to IF without touching memory.
                    state_q <= StHold;
                    req_q   <= 1'b0;
                    valid_q <= 1'b1;
                    ex_q    <= 1'b1;
                    inst_q  <= 32'h0;
                end else begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    ex_q    <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StReq: begin
                        if (bus.inst_addr_ok) begin
                            state_q <= StWait;
                            req_q   <= 1'b0;
                        end else if (bus.PF_Flush) begin
                            // Request cannot be retracted; redirect once it is accepted.
                            redirect_pend_q <= 1'b1;
                        end
                    end
                    StWait: begin
                        if (data_keep) begin
                            state_q <= StHold;
                            inst_q  <= bus.inst_rdata;
                            valid_q <= 1'b1;
                            ex_q    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // More than two abandoned fetches in flight means the flush source broke the protocol.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (drop_sum <= 3'd2) else $error("pf_fetch: drop_cnt overflow");
        end
    end
`endif

    assign bus.inst_req  = req_q;
    assign bus.inst_addr = req_addr_q;
    assign bus.PF_PC     = pc_q;
    assign bus.PF_valid  = valid_q;
    assign bus.PF_inst   = inst_q;
    assign bus.PF_ex     = ex_q;

endmodule

// File: tb/tb_pf_fetch.sv
// Directed bench for pf_fetch: memory handshakes are driven by hand and every
// expected value is written out per step.
module tb_pf_fetch;
    logic clk;
    logic resetn;
    int   total;
    int   bad;

    pf_fetch_if bus ();

    pf_fetch dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then settled 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn           = 1'b0;
        bus.NPC          = 32'h0;
        bus.PCWr         = 1'b1;
        bus.PF_Flush     = 1'b0;
        bus.IF_allowin   = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;

        // Reset values.
        #12;
        chk("rst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("rst_addr", bus.inst_addr, 32'hBFC0_0000);
        chk("rst_pc", bus.PF_PC, 32'hBFC0_0000);
        chk("rst_valid", {31'b0, bus.PF_valid}, 32'd0);
        chk("rst_inst", bus.PF_inst, 32'h0);
        chk("rst_ex", {31'b0, bus.PF_ex}, 32'd0);

        // First fetch from the reset vector.
        tick();
        resetn = 1'b1;
        tick();
        chk("boot_req", {31'b0, bus.inst_req}, 32'd1);
        chk("boot_addr", bus.inst_addr, 32'hBFC0_0000);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("boot_req_drop", {31'b0, bus.inst_req}, 32'd0);
        tick();
        chk("boot_wait_valid", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h2402_0001;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("boot_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("boot_inst", bus.PF_inst, 32'h2402_0001);
        chk("boot_ex", {31'b0, bus.PF_ex}, 32'd0);

        // Hold while IF is full, then hand off to BFC0_0004.
        bus.NPC = 32'hBFC0_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {31'b0, bus.PF_valid}, 32'd1);
            chk("hold_inst", bus.PF_inst, 32'h2402_0001);
            chk("hold_pc", bus.PF_PC, 32'hBFC0_0000);
        end
        bus.IF_allowin = 1'b1;
        tick();
        bus.IF_allowin = 1'b0;
        chk("handoff_req", {31'b0, bus.inst_req}, 32'd1);
        chk("handoff_addr", bus.inst_addr, 32'hBFC0_0004);
        chk("handoff_pc", bus.PF_PC, 32'hBFC0_0004);
        chk("handoff_valid", {31'b0, bus.PF_valid}, 32'd0);

        // Flush while waiting: stale DEADBEEF is discarded.
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.PF_Flush = 1'b1;
        bus.NPC      = 32'hBFC0_0380;
        tick();
        bus.PF_Flush = 1'b0;
        chk("wflush_req", {31'b0, bus.inst_req}, 32'd1);
        chk("wflush_addr", bus.inst_addr, 32'hBFC0_0380);
        chk("wflush_pc", bus.PF_PC, 32'hBFC0_0380);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        tick();
        chk("wflush_drop_valid", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_rdata = 32'h3C1D_0001;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("wflush_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("wflush_inst", bus.PF_inst, 32'h3C1D_0001);

        // PCWr low blocks the handoff even with IF ready.
        bus.IF_allowin = 1'b1;
        bus.PCWr       = 1'b0;
        bus.NPC        = 32'hBFC0_0384;
        tick();
        chk("stall_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("stall_pc", bus.PF_PC, 32'hBFC0_0380);
        chk("stall_req", {31'b0, bus.inst_req}, 32'd0);
        bus.PCWr = 1'b1;
        tick();
        bus.IF_allowin = 1'b0;
        chk("stall_go_addr", bus.inst_addr, 32'hBFC0_0384);

        // Flush in REQ with addr_ok withheld two cycles.
        bus.PF_Flush = 1'b1;
        bus.NPC      = 32'hBFC0_0380;
        tick();
        bus.PF_Flush = 1'b0;
        chk("rflush_addr_held1", bus.inst_addr, 32'hBFC0_0384);
        chk("rflush_req_held", {31'b0, bus.inst_req}, 32'd1);
        chk("rflush_pc", bus.PF_PC, 32'hBFC0_0380);
        tick();
        chk("rflush_addr_held2", bus.inst_addr, 32'hBFC0_0384);
        bus.inst_addr_ok = 1'b1;
        tick();
        chk("rflush_reissue_req", {31'b0, bus.inst_req}, 32'd1);
        chk("rflush_reissue_addr", bus.inst_addr, 32'hBFC0_0380);
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("rflush_wait_req", {31'b0, bus.inst_req}, 32'd0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        tick();
        chk("rflush_drop_valid", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_rdata = 32'h1111_1111;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("rflush_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("rflush_inst", bus.PF_inst, 32'h1111_1111);

        // Misaligned handoff target raises AdEL with no request.
        bus.IF_allowin = 1'b1;
        bus.NPC        = 32'hBFC0_0002;
        tick();
        bus.IF_allowin = 1'b0;
        chk("adel_req", {31'b0, bus.inst_req}, 32'd0);
        chk("adel_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("adel_ex", {31'b0, bus.PF_ex}, 32'd1);
        chk("adel_inst", bus.PF_inst, 32'h0);
        chk("adel_pc", bus.PF_PC, 32'hBFC0_0002);
        tick();
        chk("adel_req_stays", {31'b0, bus.inst_req}, 32'd0);

        // Back-to-back flushes: two responses dropped, third delivered.
        bus.IF_allowin = 1'b1;
        bus.NPC        = 32'hBFC0_0010;
        tick();
        bus.IF_allowin = 1'b0;
        chk("b2b_ex_clear", {31'b0, bus.PF_ex}, 32'd0);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.PF_Flush = 1'b1;
        bus.NPC      = 32'hBFC0_0020;
        tick();
        bus.NPC          = 32'hBFC0_0030;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.PF_Flush = 1'b0;
        chk("b2b_addr", bus.inst_addr, 32'hBFC0_0030);
        chk("b2b_req", {31'b0, bus.inst_req}, 32'd1);
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hAAAA_0001;
        tick();
        chk("b2b_drop1", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_rdata = 32'hAAAA_0002;
        tick();
        chk("b2b_drop2", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_rdata = 32'hAAAA_0003;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("b2b_valid", {31'b0, bus.PF_valid}, 32'd1);
        chk("b2b_inst", bus.PF_inst, 32'hAAAA_0003);

        // Flush coinciding with the live response: response consumed, nothing to drop.
        bus.IF_allowin = 1'b1;
        bus.NPC        = 32'hBFC0_0040;
        tick();
        bus.IF_allowin   = 1'b0;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.PF_Flush     = 1'b1;
        bus.NPC          = 32'hBFC0_0050;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h5555_5555;
        tick();
        bus.PF_Flush     = 1'b0;
        bus.inst_data_ok = 1'b0;
        chk("coinc_addr", bus.inst_addr, 32'hBFC0_0050);
        chk("coinc_valid", {31'b0, bus.PF_valid}, 32'd0);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h6666_6666;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("coinc_valid2", {31'b0, bus.PF_valid}, 32'd1);
        chk("coinc_inst", bus.PF_inst, 32'h6666_6666);

        // Asynchronous reset in the middle of a fetch.
        bus.IF_allowin = 1'b1;
        bus.NPC        = 32'hBFC0_0060;
        tick();
        bus.IF_allowin   = 1'b0;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_pc", bus.PF_PC, 32'hBFC0_0000);
        chk("mid_rst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, bus.PF_valid}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_rst_reboot_req", {31'b0, bus.inst_req}, 32'd1);
        chk("mid_rst_reboot_addr", bus.inst_addr, 32'hBFC0_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pf_fetch.md
PF_FETCH -- requirements
Module: pf_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 NPC  input  32  next fetch address from next-PC logic.
REQ-004 PCWr  input  1  1 = downstream permits PC advance; 0 = stall.
REQ-005 PF_Flush  input  1  redirect: abandon current fetch and restart at NPC.
REQ-006 IF_allowin  input  1  IF stage can accept an instruction this cycle.
REQ-007 inst_req  output  1  instruction-memory request valid.
REQ-008 inst_addr  output  32  request address; stable while inst_req=1 and inst_addr_ok=0.
REQ-009 inst_addr_ok  input  1  memory accepted the request this cycle.
REQ-010 inst_data_ok  input  1  read data valid this cycle; responses return in request order.
REQ-011 inst_rdata  input  32  read data.
REQ-012 PF_PC  output  32  address of the fetch currently owned by the stage.
REQ-013 PF_valid  output  1  PF_inst/PF_ex valid for IF.
REQ-014 PF_inst  output  32  fetched instruction word.
REQ-015 PF_ex  output  1  AdEL: PF_PC[1:0] != 0.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD; a 2-bit drop_cnt SHALL count outstanding responses to discard.
REQ-017 IDLE: SHALL move to REQ on the first clock after reset release.
REQ-018 REQ: inst_req=1, inst_addr=req_addr; on inst_addr_ok, SHALL move to WAIT.
REQ-019 WAIT: on inst_data_ok with drop_cnt=0, SHALL latch inst_rdata into PF_inst, set PF_valid=1, and move to HOLD.
REQ-020 On inst_data_ok with drop_cnt>0, in any state, SHALL discard the data and decrement drop_cnt; PF_inst and state unchanged.
REQ-021 HOLD: PF_valid=1; when IF_allowin & PCWr & !PF_Flush, SHALL load PF_PC and req_addr from NPC, clear PF_valid, and move to REQ in the same edge.
REQ-022 HOLD with IF_allowin=0 or PCWr=0: PF_PC, PF_inst, PF_valid SHALL hold.
REQ-023 PF_Flush SHALL have priority over every other transition, and PF_PC SHALL load NPC on that edge in every state.
REQ-024 Flush in HOLD: SHALL drop the buffered word, clear PF_valid, set req_addr=NPC, and move to REQ.
REQ-025 Flush in WAIT: SHALL increment drop_cnt (unless inst_data_ok the same cycle with drop_cnt=0, which consumes it), set req_addr=NPC, and move to REQ.
REQ-026 Flush in REQ with inst_addr_ok=1: SHALL increment drop_cnt, set req_addr=NPC, and stay in REQ.
REQ-027 Flush in REQ with inst_addr_ok=0: req/address SHALL be held (no retraction); redirect_pend SHALL be set; on the later addr_ok, SHALL increment drop_cnt, set req_addr=PF_PC, and stay in REQ.
REQ-028 Further flushes while redirect_pend=1 SHALL only update PF_PC.
REQ-029 drop_cnt SHALL never exceed 2; a flush that would exceed it is a protocol violation, flagged by a simulation assertion.
REQ-030 Address error: when NPC[1:0]!=0 is loaded, SHALL issue no request; next state HOLD with PF_ex=1, PF_inst=0, PF_valid=1.
REQ-031 PF_ex SHALL equal 0 for every word returned by memory.
REQ-032 Simultaneous inst_data_ok and handoff/flush SHALL be resolved per REQ-020/REQ-025 in one edge, with no response lost or double-counted.

Reset
REQ-033 On resetn=0, asynchronously: state=IDLE, PF_PC=req_addr=32'hBFC0_0000, drop_cnt=0, redirect_pend=0, PF_valid=0, PF_inst=0, PF_ex=0, inst_req=0.
REQ-034 Reset mid-transaction SHALL abandon all outstanding state; the memory model is reset concurrently.

Verification
REQ-035 Reset release, addr_ok at cycle 1, data_ok at cycle 3 with 32'h2402_0001 -> inst_addr=BFC0_0000, PF_valid=1 at cycle 4, PF_inst=2402_0001.
REQ-036 HOLD with IF_allowin=0 for 3 cycles, then IF_allowin=PCWr=1, NPC=BFC0_0004 -> PF_valid held 3 cycles, then REQ at BFC0_0004.
REQ-037 PF_Flush in WAIT, NPC=BFC0_0380 -> next request to BFC0_0380; old data_ok (DEADBEEF) discarded; PF_inst comes only from the new response.
REQ-038 PF_Flush in REQ with addr_ok withheld 2 cycles -> inst_addr stays old value until addr_ok, then re-request to BFC0_0380; exactly one response dropped.
REQ-039 NPC=BFC0_0002 on handoff -> inst_req stays 0; PF_valid=1, PF_ex=1, PF_inst=0 next cycle.
REQ-040 Back-to-back flushes in WAIT then REQ+addr_ok -> drop_cnt reaches 2; two responses discarded; third delivered.
